// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one word at a time from instruction
// memory, holds it for the decoder and flags a sticky fetch timeout.
module instruction_fetch #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] i_addr,
   output logic        pc_inc,
   input  logic        flush,
   input  logic        halt,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_data,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        fetch_err
);

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_FULL,
      S_FLUSH,
      S_ERROR
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  wait_q;
   logic [7:0]  wait_d;
   logic [7:0]  wait_inc;
   logic        init_q;
   logic [15:0] instr_q;
   logic        valid_q;
   logic        pc_q;
   logic        rd_q;
   logic        err_q;
   logic        capture;

   assign wait_inc = wait_q + 8'd1;
   assign capture  = (state_q == S_FETCH) && (state_d == S_FULL);

   // Next state: flush wins over everything, including ack and ready.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_FLUSH;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (init_q && !halt) state_d = S_FETCH;
            end
            S_FETCH: begin
               if (mem_ack) begin
                  state_d = S_FULL;
               end else if (wait_inc == TMO) begin
                  state_d = S_ERROR;
               end
            end
            S_FULL: begin
               if (instr_ready) begin
                  state_d = halt ? S_IDLE : S_FETCH;
               end
            end
            S_FLUSH: begin
               state_d = halt ? S_IDLE : S_FETCH;
            end
            S_ERROR: begin
               state_d = S_ERROR;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Wait counter: zero on FETCH entry, counts ack-less FETCH cycles.
   always_comb begin
      wait_d = wait_q;
      if (state_d == S_FETCH && state_q != S_FETCH) begin
         wait_d = 8'd0;
      end else if (state_q == S_FETCH && !mem_ack && !flush) begin
         wait_d = wait_inc;
      end
   end

   // All state and registered outputs; init_q delays the first fetch
   // by one edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wait_q  <= 8'd0;
         init_q  <= 1'b0;
         instr_q <= 16'h0000;
         valid_q <= 1'b0;
         pc_q    <= 1'b0;
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         init_q  <= 1'b1;
         rd_q    <= (state_d == S_FETCH);
         valid_q <= (state_d == S_FULL);
         err_q   <= (state_d == S_ERROR);
         pc_q    <= capture;
         if (capture) begin
            instr_q <= mem_data;
         end
      end
   end

   assign mem_rd      = rd_q;
   assign mem_addr    = rd_q ? i_addr : 16'h0000;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;
   // A flush in the pulse cycle cancels the increment.
   assign pc_inc      = pc_q & ~flush;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic,
// checked against a phase-level model and an instruction scoreboard.
module tb_instruction_fetch;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_n;
   logic [15:0] i_addr;
   logic        pc_inc;
   logic        flush;
   logic        halt;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_err;

   int errs;
   int checks;

   instruction_fetch #(.TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_addr      (i_addr),
      .pc_inc      (pc_inc),
      .flush       (flush),
      .halt        (halt),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {P_IDLE, P_FETCH, P_FULL, P_FLUSH, P_ERR} ph_t;

   ph_t         ph;
   int          waits;
   bit          started;
   bit          pulse;
   logic [15:0] q[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      ph      = P_IDLE;
      waits   = 0;
      started = 0;
      pulse   = 0;
      q.delete();
   endtask

   task automatic model_edge();
      bit np;
      np = 0;
      if (flush) begin
         ph = P_FLUSH;
         q.delete();
      end else begin
         case (ph)
            P_IDLE: if (started && !halt) begin
               ph    = P_FETCH;
               waits = 0;
            end
            P_FETCH: if (mem_ack) begin
               q.push_back(mem_data);
               np = 1;
               ph = P_FULL;
            end else begin
               waits++;
               if (waits >= TMO) ph = P_ERR;
            end
            P_FULL: if (instr_ready) begin
               ph    = halt ? P_IDLE : P_FETCH;
               waits = 0;
            end
            P_FLUSH: begin
               ph    = halt ? P_IDLE : P_FETCH;
               waits = 0;
            end
            default: ;
         endcase
      end
      started = 1;
      pulse   = np;
   endtask

   task automatic check_outputs();
      bit e_rd;
      e_rd = (ph == P_FETCH);
      chk("mem_rd", 32'(mem_rd), 32'(e_rd));
      chk("mem_addr", 32'(mem_addr), e_rd ? 32'(i_addr) : 32'd0);
      chk("instr_valid", 32'(instr_valid), 32'(ph == P_FULL));
      chk("pc_inc", 32'(pc_inc), 32'(pulse && !flush));
      chk("fetch_err", 32'(fetch_err), 32'(ph == P_ERR));
      if (ph == P_FULL) begin
         if (q.size() == 0) begin
            chk("instr_expected", 32'd0, 32'd1);
         end else begin
            chk("instr_held", 32'(instr), 32'(q[0]));
         end
      end
   endtask

   task automatic cycle(input bit f, input bit h, input bit a,
                        input bit r, input logic [15:0] ad,
                        input logic [15:0] d);
      flush       = f;
      halt        = h;
      mem_ack     = a;
      instr_ready = r;
      i_addr      = ad;
      mem_data    = d;
      #3;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic reset_mid(input string nm);
      mem_ack = 1'b0;
      flush   = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk({nm, "_mem_rd"}, 32'(mem_rd), 32'd0);
      chk({nm, "_valid"}, 32'(instr_valid), 32'd0);
      chk({nm, "_pc_inc"}, 32'(pc_inc), 32'd0);
      chk({nm, "_err"}, 32'(fetch_err), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: every transfer must deliver the oldest word.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !flush) begin
         if (q.size() == 0) begin
            chk("xfer_unexpected", 32'(instr), 32'hFFFF_FFFF);
         end else begin
            chk("xfer_instr", 32'(instr), 32'(q.pop_front()));
         end
      end
   end

   initial begin
      errs        = 0;
      checks      = 0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      halt        = 1'b0;
      mem_ack     = 1'b0;
      instr_ready = 1'b0;
      i_addr      = 16'h0000;
      mem_data    = 16'h0000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc_inc", 32'(pc_inc), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      rst_n = 1'b1;

      // Two idle cycles, then basic fetch at 0x0010.
      cycle(0, 0, 0, 0, 16'h0010, 16'h0000);
      cycle(0, 0, 0, 0, 16'h0010, 16'h0000);
      cycle(0, 0, 1, 0, 16'h0010, 16'hA5C3);
      // Backpressure for five cycles, then transfer.
      repeat (5) cycle(0, 0, 0, 0, 16'h0011, 16'hFFFF);
      cycle(0, 0, 0, 1, 16'h0011, 16'hFFFF);
      // Flush racing an ack.
      cycle(1, 0, 1, 0, 16'h0020, 16'h1234);
      cycle(0, 0, 0, 0, 16'h0030, 16'h0000);
      // Timeout into ERROR, ack ignored there, flush recovers.
      repeat (TMO) cycle(0, 0, 0, 0, 16'h0030, 16'h0000);
      repeat (2) cycle(0, 0, 1, 1, 16'h0030, 16'hBEEF);
      cycle(1, 0, 0, 0, 16'h0040, 16'h0000);
      cycle(0, 0, 0, 0, 16'h0040, 16'h0000);
      // Halt while FULL, transfer to IDLE, then resume.
      cycle(0, 1, 1, 0, 16'h0040, 16'h5A5A);
      cycle(0, 1, 0, 0, 16'h0041, 16'h0000);
      cycle(0, 1, 0, 1, 16'h0041, 16'h0000);
      cycle(0, 1, 0, 0, 16'h0041, 16'h0000);
      cycle(0, 0, 0, 0, 16'h0041, 16'h0000);
      cycle(0, 0, 0, 0, 16'h0041, 16'h0000);
      // Async reset in FETCH, then in FULL with pc_inc high.
      reset_mid("rst_fetch");
      cycle(0, 0, 0, 0, 16'h0050, 16'h0000);
      cycle(0, 0, 0, 0, 16'h0050, 16'h0000);
      cycle(0, 0, 1, 0, 16'h0050, 16'h7E7E);
      reset_mid("rst_full");

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 99) < 5,
               $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 45,
               $urandom_range(0, 99) < 55,
               16'($urandom), 16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TIMEOUT, 15: maximum cycles waited for mem_ack before fault; legal range 1..255.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock; all state changes on its rising edge.
- rst_n, in, 1: reset; asynchronous, active-low.
- i_addr, in, 16: current instruction address from the program counter.
- pc_inc, out, 1: one-cycle pulse; drives the program counter increment.
- flush, in, 1: branch/load in progress; discard fetch state.
- halt, in, 1: inhibit the start of new fetches.
- mem_rd, out, 1: instruction memory read request.
- mem_addr, out, 16: read address.
- mem_ack, in, 1: read data valid this cycle.
- mem_data, in, 16: read data.
- instr, out, 16: held instruction word.
- instr_valid, out, 1: instr holds an unconsumed instruction.
- instr_ready, in, 1: the decoder accepts instr this cycle.
- fetch_err, out, 1: sticky timeout fault.

Function
REQ-003 The block SHALL implement the states IDLE, FETCH, FULL, FLUSH and ERROR.
REQ-004 In IDLE with halt=0 and flush=0, the block SHALL move to FETCH on the next edge; with halt=1 it SHALL remain in IDLE.
REQ-005 In FETCH, mem_rd SHALL be 1 and mem_addr SHALL equal i_addr combinationally; mem_addr SHALL be 16'h0000 whenever mem_rd=0.
REQ-006 FETCH with mem_ack=1 and flush=0 SHALL, at the edge:
- capture mem_data into instr;
- set instr_valid=1;
- assert pc_inc for exactly that one following cycle;
- move to FULL.
REQ-007 In FULL, the transfer SHALL occur when instr_valid=1 and instr_ready=1. On that edge instr_valid SHALL clear and the block SHALL go to FETCH (halt=0) or IDLE (halt=1).
REQ-008 instr SHALL remain stable while instr_valid=1 and no transfer has occurred.
REQ-009 Fetch-to-valid latency:
- mem_ack in cycle N gives instr_valid=1 in cycle N+1.
- A transfer in cycle M gives mem_rd=1 in cycle M+1.
- Maximum throughput is one instruction per 2 cycles when mem_ack is combinational.
REQ-010 flush=1 in any state except ERROR SHALL, at the edge:
- clear instr_valid;
- suppress pc_inc;
- discard any mem_ack/mem_data in the same cycle;
- enter FLUSH.
REQ-011 flush SHALL take priority over mem_ack and instr_ready in the same cycle.
REQ-012 FLUSH SHALL last exactly one cycle with mem_rd=0, so the program counter load settles. It SHALL then go to FETCH (halt=0) or IDLE (halt=1). flush held high SHALL keep the block in FLUSH.
REQ-013 A wait counter SHALL clear on FETCH entry and increment each FETCH cycle with mem_ack=0.
REQ-014 When the wait counter reaches TIMEOUT without mem_ack, the block SHALL enter ERROR and set fetch_err=1.
REQ-015 In ERROR: mem_rd=0, instr_valid=0, pc_inc=0, and fetch_err stays 1.
REQ-016 Only flush=1 SHALL leave ERROR; it SHALL clear fetch_err and enter FLUSH.
REQ-017 halt SHALL NOT abort an outstanding FETCH or drop a valid instr; it only gates the entry into FETCH.
REQ-018 pc_inc SHALL never be asserted in two consecutive cycles and SHALL never coincide with flush=1.
REQ-019 mem_ack outside FETCH SHALL be ignored.

Reset
REQ-020 rst_n=0 SHALL, asynchronously, force:
- state to IDLE;
- instr to 16'h0000;
- instr_valid, pc_inc, mem_rd and fetch_err to 0;
- the wait counter to 0.
REQ-021 Reset asserted mid-fetch SHALL abandon the request immediately with no pc_inc.
REQ-022 After rst_n rises, the first mem_rd SHALL appear no earlier than the second rising edge.

Verification
REQ-023 Basic fetch: i_addr=16'h0010, halt=0, mem_ack=1 on the first mem_rd cycle with mem_data=16'hA5C3 -> mem_addr=16'h0010; next cycle instr=16'hA5C3, instr_valid=1, pc_inc=1 for one cycle.
REQ-024 Backpressure: instr_ready=0 for 5 cycles, then 1 -> instr stable for 5 cycles; mem_rd=0 throughout; mem_rd=1 on the cycle after the transfer.
REQ-025 Flush race: flush=1 and mem_ack=1 in the same cycle, mem_data=16'h1234 -> instr_valid stays 0, no pc_inc, one FLUSH cycle, then mem_rd=1.
REQ-026 Timeout: TIMEOUT=4, mem_ack held 0 -> fetch_err=1 after 4 FETCH cycles, then mem_rd=0; a flush pulse clears fetch_err and fetching resumes after one FLUSH cycle.
REQ-027 Halt: halt=1 while FULL, then a transfer -> IDLE with mem_rd=0; halt=0 -> mem_rd=1 on the next cycle.
REQ-028 Async reset: rst_n=0 in the middle of FETCH between clock edges -> mem_rd, instr_valid and pc_inc go to 0 before the next edge.
